// File: rtl/btn_conditioner_pkg.sv
// Shared button constants: default debounce length, button indices and the
// one-hot press codes the downstream control FSM decodes.
package btn_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 200000;

  localparam int BTN_0 = 0;
  localparam int BTN_1 = 1;
  localparam int BTN_2 = 2;
  localparam int BTN_3 = 3;

  localparam logic [3:0] PRESS_BTN_0 = 4'b0001;
  localparam logic [3:0] PRESS_BTN_1 = 4'b0010;
  localparam logic [3:0] PRESS_BTN_2 = 4'b0100;
  localparam logic [3:0] PRESS_BTN_3 = 4'b1000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-FF synchroniser, persistence counter, debounced level
// and registered one-cycle press/release pulses.
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level,
  output logic press,
  output logic rel
);

  logic [1:0]       sync_n;
  logic             s;
  logic [CNT_W-1:0] cnt;

  assign s = ~sync_n[1];

  // Any return of s to the accepted level restarts the count, so bounces
  // shorter than DEBOUNCE_CYCLES never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_n <= 2'b11;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_n <= {sync_n[0], raw_n};
      press  <= 1'b0;
      rel    <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= s;
        cnt   <= '0;
        press <= s;
        rel   <= ~s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounced push-button front end: per-channel conditioning plus a
// lowest-index press encoder and a multiple-buttons-held flag.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter  int N_BTN           = 4,
  parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  localparam int IDX_W           = idx_width(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] button_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             press_valid,
  output logic [IDX_W-1:0] press_idx,
  output logic             multi_held
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw_n(button_n[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

  assign press_valid = |btn_press;

  // Descending scan so the lowest set index wins.
  always_comb begin
    press_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_press[i]) press_idx = IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_held = |(btn_level & (btn_level - N_BTN'(1)));

endmodule
